// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: input synchroniser and glitch filter,
// 11-bit frame decoder with parity/stop/timeout checks, FWFT byte FIFO
// and a level interrupt for the host.
module ps2_rx_fifo #(
    parameter int unsigned CLK_HZ       = 25_000_000,
    parameter int unsigned PS2_HZ       = 10_000,
    parameter int unsigned TIMEOUT_BITS = 2,
    parameter int unsigned FILTER_LEN   = 4,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                ps2_clk,
    input  logic                                ps2_data,
    input  logic                                rd_en,
    input  logic                                int_clear,
    output logic [7:0]                          rd_data,
    output logic                                rd_valid,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_count,
    output logic                                parity_err,
    output logic                                frame_err,
    output logic                                overflow,
    output logic                                interrupt
);

    localparam int unsigned BIT_CYC = CLK_HZ / PS2_HZ;
    localparam int unsigned TO_CYC  = TIMEOUT_BITS * BIT_CYC;
    localparam int unsigned TW      = $clog2(TO_CYC + 1);
    localparam int unsigned FW      = $clog2(FILTER_LEN + 1);
    localparam int unsigned AW      = $clog2(FIFO_DEPTH);
    localparam int unsigned CW      = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    // Input path state
    logic [1:0]    clk_s_q, clk_s_d, dat_s_q, dat_s_d;
    logic          clk_f_q, clk_f_d, dat_f_q, dat_f_d;
    logic [FW-1:0] clk_cnt_q, clk_cnt_d, dat_cnt_q, dat_cnt_d;
    logic          fall;

    // Frame decoder state
    state_t        state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    sh_q, sh_d;
    logic          par_q, par_d;
    logic [TW-1:0] to_q, to_d;
    logic          push, set_perr, set_ferr;

    // FIFO and flag state
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic          perr_q, perr_d, ferr_q, ferr_d, ovf_q, ovf_d;
    logic          int_q, int_d;
    logic          pop, full, set_ovf;

    // Synchroniser shift and glitch filter: level flips after FILTER_LEN differing samples
    always_comb begin
        clk_s_d   = {clk_s_q[0], ps2_clk};
        dat_s_d   = {dat_s_q[0], ps2_data};
        clk_f_d   = clk_f_q;
        dat_f_d   = dat_f_q;
        clk_cnt_d = '0;
        dat_cnt_d = '0;
        if (clk_s_q[1] != clk_f_q) begin
            if (clk_cnt_q == FW'(FILTER_LEN - 1)) clk_f_d = clk_s_q[1];
            else                                  clk_cnt_d = clk_cnt_q + FW'(1);
        end
        if (dat_s_q[1] != dat_f_q) begin
            if (dat_cnt_q == FW'(FILTER_LEN - 1)) dat_f_d = dat_s_q[1];
            else                                  dat_cnt_d = dat_cnt_q + FW'(1);
        end
        fall = clk_f_q & ~clk_f_d;
    end

    // Frame decoder with mid-frame timeout abort
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        sh_d     = sh_q;
        par_d    = par_q;
        to_d     = '0;
        push     = 1'b0;
        set_perr = 1'b0;
        set_ferr = 1'b0;
        if (state_q != S_IDLE && to_q == TW'(TO_CYC)) begin
            state_d  = S_IDLE;
            set_ferr = 1'b1;
        end else begin
            if (state_q != S_IDLE && !fall) to_d = to_q + TW'(1);
            if (fall) begin
                case (state_q)
                    S_IDLE: begin
                        if (!dat_f_q) begin
                            state_d = S_DATA;
                            idx_d   = 3'd0;
                        end else begin
                            set_ferr = 1'b1;
                        end
                    end
                    S_DATA: begin
                        sh_d[idx_q] = dat_f_q;
                        idx_d       = idx_q + 3'd1;
                        if (idx_q == 3'd7) state_d = S_PARITY;
                    end
                    S_PARITY: begin
                        par_d   = dat_f_q;
                        state_d = S_STOP;
                    end
                    S_STOP: begin
                        state_d = S_IDLE;
                        if (!dat_f_q)              set_ferr = 1'b1;
                        else if (^{sh_q, par_q})   push     = 1'b1;
                        else                       set_perr = 1'b1;
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    // FWFT FIFO, sticky flags and registered host-facing outputs
    always_comb begin
        full     = (cnt_q == CW'(FIFO_DEPTH));
        pop      = rd_en & (cnt_q != '0);
        set_ovf  = push & full & ~pop;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push && !set_ovf) begin
            mem_d[wr_ptr_q] = sh_q;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !set_ovf && !pop) cnt_d = cnt_q + CW'(1);
        else if (pop && !(push && !set_ovf)) cnt_d = cnt_q - CW'(1);
        rd_valid_d = (cnt_d != '0);
        rd_data_d  = rd_valid_d ? mem_d[rd_ptr_d] : 8'h00;
        perr_d     = (perr_q & ~int_clear) | set_perr;
        ferr_d     = (ferr_q & ~int_clear) | set_ferr;
        ovf_d      = (ovf_q  & ~int_clear) | set_ovf;
        int_d      = rd_valid_d | perr_d | ferr_d | ovf_d;
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_s_q    <= 2'b11;
            dat_s_q    <= 2'b11;
            clk_f_q    <= 1'b1;
            dat_f_q    <= 1'b1;
            clk_cnt_q  <= '0;
            dat_cnt_q  <= '0;
            state_q    <= S_IDLE;
            idx_q      <= 3'd0;
            sh_q       <= 8'h00;
            par_q      <= 1'b0;
            to_q       <= '0;
            mem_q      <= '{default: 8'h00};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            ovf_q      <= 1'b0;
            int_q      <= 1'b0;
        end else begin
            clk_s_q    <= clk_s_d;
            dat_s_q    <= dat_s_d;
            clk_f_q    <= clk_f_d;
            dat_f_q    <= dat_f_d;
            clk_cnt_q  <= clk_cnt_d;
            dat_cnt_q  <= dat_cnt_d;
            state_q    <= state_d;
            idx_q      <= idx_d;
            sh_q       <= sh_d;
            par_q      <= par_d;
            to_q       <= to_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            ovf_q      <= ovf_d;
            int_q      <= int_d;
        end
    end

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign fifo_count = cnt_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign overflow   = ovf_q;
    assign interrupt  = int_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: frame-level reference model (byte queue + flags).
module tb_ps2_rx_fifo;

    localparam int unsigned CLK_HZ       = 1_000_000;
    localparam int unsigned PS2_HZ       = 10_000;
    localparam int unsigned TIMEOUT_BITS = 2;
    localparam int unsigned FILTER_LEN   = 4;
    localparam int unsigned FIFO_DEPTH   = 4;
    localparam int unsigned BIT_CYC      = CLK_HZ / PS2_HZ;
    localparam int unsigned EDGE_LAT     = 1 + FILTER_LEN;
    localparam int unsigned CW           = $clog2(FIFO_DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset, ps2_clk, ps2_data, rd_en, int_clear;
    logic [7:0]    rd_data;
    logic          rd_valid, parity_err, frame_err, overflow, interrupt;
    logic [CW-1:0] fifo_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];
    logic       m_perr, m_ferr, m_ovf;

    ps2_rx_fifo #(
        .CLK_HZ(CLK_HZ), .PS2_HZ(PS2_HZ), .TIMEOUT_BITS(TIMEOUT_BITS),
        .FILTER_LEN(FILTER_LEN), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .rd_en(rd_en), .int_clear(int_clear), .rd_data(rd_data),
        .rd_valid(rd_valid), .fifo_count(fifo_count), .parity_err(parity_err),
        .frame_err(frame_err), .overflow(overflow), .interrupt(interrupt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model; called just after a negedge
    task automatic check_state(input string w);
        logic [7:0] head;
        logic       nonempty;
        nonempty = (exp_q.size() != 0);
        head     = nonempty ? exp_q[0] : 8'h00;
        chk({w, " rd_valid"},   32'(rd_valid),   32'(nonempty));
        chk({w, " rd_data"},    32'(rd_data),    32'(head));
        chk({w, " fifo_count"}, 32'(fifo_count), 32'(exp_q.size()));
        chk({w, " parity_err"}, 32'(parity_err), 32'(m_perr));
        chk({w, " frame_err"},  32'(frame_err),  32'(m_ferr));
        chk({w, " overflow"},   32'(overflow),   32'(m_ovf));
        chk({w, " interrupt"},  32'(interrupt),  32'(nonempty | m_perr | m_ferr | m_ovf));
    endtask

    // One PS/2 bit cell; optional rd_en pulse aligned to the decoded falling edge
    task automatic drive_bit(input logic v, input bit pop_hook);
        ps2_data = v;
        repeat (BIT_CYC / 4) @(negedge clk);
        ps2_clk = 1'b0;
        if (pop_hook) begin
            repeat (EDGE_LAT) @(negedge clk);
            rd_en = 1'b1;
            @(negedge clk);
            rd_en = 1'b0;
            repeat (BIT_CYC / 2 - EDGE_LAT - 1) @(negedge clk);
        end else begin
            repeat (BIT_CYC / 2) @(negedge clk);
        end
        ps2_clk = 1'b1;
        repeat (BIT_CYC / 4) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input bit pop_hook);
        logic par;
        par = (~^b) ^ bad_par;
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i], 1'b0);
        drive_bit(par, 1'b0);
        drive_bit(~bad_stop, pop_hook);
        ps2_data = 1'b1;
        repeat (20) @(negedge clk);
        if (pop_hook && exp_q.size() != 0) void'(exp_q.pop_front());
        if (bad_stop)                          m_ferr = 1'b1;
        else if (bad_par)                      m_perr = 1'b1;
        else if (exp_q.size() < FIFO_DEPTH)    exp_q.push_back(b);
        else                                   m_ovf = 1'b1;
    endtask

    task automatic pop_byte();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
    endtask

    task automatic clear_int();
        int_clear = 1'b1;
        @(negedge clk);
        int_clear = 1'b0;
        m_perr = 1'b0;
        m_ferr = 1'b0;
        m_ovf  = 1'b0;
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_perr = 1'b0;
        m_ferr = 1'b0;
        m_ovf  = 1'b0;
    endtask

    initial begin
        reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; rd_en = 1'b0; int_clear = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_state("in_reset");
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check_state("after_reset");

        // Single good byte, then pop
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        check_state("good_1c");
        pop_byte();
        check_state("pop_1c");

        // Parity error, cleared by int_clear
        send_frame(8'hF0, 1'b1, 1'b0, 1'b0);
        check_state("bad_parity");
        clear_int();
        check_state("clr_parity");

        // Stop-bit error, then timeout after a partial frame
        send_frame(8'h12, 1'b0, 1'b1, 1'b0);
        check_state("bad_stop");
        clear_int();
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b1, 1'b0);
        ps2_data = 1'b1;
        check_state("partial_pending");
        repeat (TIMEOUT_BITS * BIT_CYC + 10) @(negedge clk);
        m_ferr = 1'b1;
        check_state("timeout");
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        check_state("after_timeout");
        pop_byte();
        clear_int();
        check_state("cleaned");

        // Overflow: five bytes into a four-deep FIFO
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b0);
        check_state("overflow");
        for (int i = 0; i < 4; i++) begin
            check_state("ovf_drain");
            pop_byte();
        end
        check_state("ovf_empty");
        clear_int();

        // Full FIFO with a pop in the exact push cycle
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b0);
        check_state("full");
        send_frame(8'h05, 1'b0, 1'b0, 1'b1);
        check_state("push_pop_full");
        for (int i = 0; i < 4; i++) begin
            pop_byte();
            check_state("pp_drain");
        end

        // Short glitches on both lines while idle
        for (int i = 0; i < 3; i++) begin
            ps2_clk = 1'b0;
            repeat (2) @(negedge clk);
            ps2_clk = 1'b1;
            ps2_data = 1'b0;
            repeat (FILTER_LEN - 1) @(negedge clk);
            ps2_data = 1'b1;
            repeat (10) @(negedge clk);
        end
        check_state("glitch");

        // Reset in the middle of a frame with data and a flag pending
        send_frame(8'h55, 1'b0, 1'b0, 1'b0);
        send_frame(8'h33, 1'b1, 1'b0, 1'b0);
        check_state("pre_reset");
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b0);
        reset = 1'b1;
        ps2_data = 1'b1;
        repeat (2) @(negedge clk);
        model_reset();
        check_state("mid_reset");
        reset = 1'b0;
        repeat (20) @(negedge clk);
        send_frame(8'hAA, 1'b0, 1'b0, 1'b0);
        check_state("after_mid_reset");

        // Randomised mix of frames, reads and clears
        for (int n = 0; n < 16; n++) begin
            int unsigned op;
            op = $urandom_range(0, 9);
            if (op <= 4)      send_frame(8'($urandom), 1'b0, 1'b0, ($urandom_range(0, 3) == 0));
            else if (op == 5) send_frame(8'($urandom), 1'b1, 1'b0, 1'b0);
            else if (op == 6) send_frame(8'($urandom), 1'b0, 1'b1, 1'b0);
            else if (op <= 8) pop_byte();
            else              clear_int();
            check_state("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
- Parametrised PS/2 device-to-host receiver. Successor to the single-byte PS/2 decoder.
- Adds input synchronisation and a glitch filter, LSB-first 11-bit frame decoding with parity and stop checks, and a mid-frame timeout abort.
- Buffers good bytes in a first-word-fall-through FIFO.
- Raises a level interrupt for the host (68k bus glue) while data or errors are pending.

Parameters:
- CLK_HZ, 25_000_000, system clock frequency in Hz.
- PS2_HZ, 10_000, nominal PS/2 bit rate; bit time BIT_CYC = CLK_HZ/PS2_HZ.
- TIMEOUT_BITS, 2, mid-frame abort after TIMEOUT_BITS*BIT_CYC cycles with no falling edge.
- FILTER_LEN, 4, consecutive identical synchronised samples needed to change a filtered level (>=1).
- FIFO_DEPTH, 4, receive FIFO entries; power of two, >=2.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- ps2_clk  in  1  raw PS/2 clock line.
- ps2_data  in  1  raw PS/2 data line.
- rd_en  in  1  pop request; acts only when rd_valid=1.
- int_clear  in  1  clears the sticky error flags.
- rd_data  out  8  FIFO head byte; 0 when empty.
- rd_valid  out  1  FIFO non-empty.
- fifo_count  out  $clog2(FIFO_DEPTH+1)  number of stored bytes.
- parity_err  out  1  sticky: a frame had even parity.
- frame_err  out  1  sticky: bad start bit, bad stop bit, or timeout.
- overflow  out  1  sticky: a good byte was dropped because the FIFO was full.
- interrupt  out  1  rd_valid | parity_err | frame_err | overflow.

Behaviour:
- Reset (async):
  - FIFO empty, rd_data=0, fifo_count=0.
  - All flags 0; interrupt=0.
  - FSM in IDLE; filtered levels = 1.
  - Sync flops = 1; timeout counter = 0.
- Input path:
  - Both lines pass through a 2-flop synchroniser.
  - Each filtered level changes only after FILTER_LEN consecutive synchronised samples differ from it.
  - A falling edge is the cycle in which filtered ps2_clk goes 1->0. Data is sampled as the filtered ps2_data in that same cycle.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on falling edge, data=0 -> DATA with bit index 0. Data=1 -> set frame_err, stay IDLE.
  - DATA: shift the sample into bit[index] (LSB first). After index 7 -> PARITY.
  - PARITY: store the sampled bit -> STOP.
  - STOP: on the edge, go to IDLE.
    - Stop=1 and odd parity over data+parity bit -> push the byte.
    - Stop=0 -> set frame_err.
    - Stop=1 with parity wrong -> set parity_err.
    - Either error: byte discarded.
- Timeout:
  - Counter clears on every falling edge and in IDLE. It increments only in DATA, PARITY and STOP.
  - When it reaches TIMEOUT_BITS*BIT_CYC: go to IDLE, set frame_err, discard the partial byte.
  - Counter width must hold the terminal value; no wrap.
- FIFO (first-word fall-through):
  - A pushed byte is visible on rd_data/rd_valid and counted in fifo_count on the cycle after the stop-bit edge cycle.
  - rd_en with rd_valid=1 pops; the next head appears the following cycle.
  - rd_en while empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
  - Push when full with no pop: drop the byte, set overflow, FIFO contents unchanged.
  - Push and pop in the same cycle when full: both happen, count unchanged, no overflow.
  - Push and pop in the same cycle otherwise: count unchanged.
- Flags:
  - parity_err, frame_err and overflow clear on int_clear.
  - If a set event and int_clear coincide, set wins.
  - int_clear does not affect FIFO contents.
- Reset asserted mid-frame: the partial frame is discarded. After release, the receiver waits in IDLE for a new start bit.

Test Plan:
- Send 0x1C (bits 0,0,1,1,1,0,0,0; parity 0; stop 1) at 10 kHz -> rd_valid=1, rd_data=0x1C, fifo_count=1, no flags, interrupt=1. Pulse rd_en -> fifo_count=0, interrupt=0.
- Send 0xF0 with parity 0 (wrong) -> parity_err=1, FIFO empty, interrupt=1. int_clear -> parity_err=0, interrupt=0.
- Send 0x12 with stop bit 0 -> frame_err=1, FIFO empty. Then send 4 clock edges only and hold ps2_clk high for 2*2500+10 cycles -> frame_err=1 and the FSM accepts a following 0x1C correctly.
- Send 5 good bytes 0x01..0x05 with FIFO_DEPTH=4 and no reads -> fifo_count=4, overflow=1. Pops return 0x01..0x04 in order.
- With FIFO full, issue rd_en in the exact cycle the 5th byte pushes -> no overflow, fifo_count=4, order 0x02..0x05.
- Inject 2-cycle low glitches on ps2_clk during idle (FILTER_LEN=4) -> no state change, no flags. Assert reset mid-frame (after 5 bits) -> all outputs 0; a subsequent full 0xAA frame is received correctly.
